// File: rtl/feature_map_writer_pkg.sv
// Shared definitions for the feature-map writer and the raster-walking blocks around it.
package feature_map_writer_pkg;

  typedef enum logic {
    FMW_IDLE = 1'b0,
    FMW_RUN  = 1'b1
  } fmw_state_e;

  localparam int KERNEL   = 3;   // 3x3 stride-1 convolution, no padding
  localparam int SIGN_BIT = 31;  // IEEE-754 single sign bit

  // Output map dimension for a valid (unpadded) convolution.
  function automatic int out_dim(input int img);
    return img - KERNEL + 1;
  endfunction

  // Counter width able to hold 0..n-1, never zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_map_writer_if.sv
// Conv result stream in, map-memory write port out, plus frame status.
interface feature_map_writer_if #(
  parameter int DATA_WIDHT = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  Start;
  logic [DATA_WIDHT-1:0] Data_In;
  logic                  Valid_In;
  logic                  Mem_We;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [DATA_WIDHT-1:0] Mem_Data;
  logic                  Busy;
  logic                  Done;
  logic                  Overflow;

  modport master (
    output Start, Data_In, Valid_In,
    input  Mem_We, Mem_Addr, Mem_Data, Busy, Done, Overflow
  );

  modport slave (
    input  Start, Data_In, Valid_In,
    output Mem_We, Mem_Addr, Mem_Data, Busy, Done, Overflow
  );
endinterface

// File: rtl/feature_map_writer_raster_counter.sv
// Column/row raster counter: col wraps W-1 -> 0 and bumps row; last flags (W-1, H-1).
module raster_counter
  import feature_map_writer_pkg::*;
#(
  parameter int W  = 3,
  parameter int H  = 3,
  parameter int CW = cnt_w(W),
  parameter int RW = cnt_w(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end, row_end;

  assign col_end = (col_q == CW'(W - 1));
  assign row_end = (row_q == RW'(H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end & row_end;

endmodule

// File: rtl/feature_map_writer.sv
// Writes the conv result stream in raster order into the feature-map memory, with
// optional ReLU, a frame-done pulse and a sticky overflow flag for dropped words.
module feature_map_writer
  import feature_map_writer_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int RELU_EN    = 0
) (
  input logic                 clk,
  input logic                 rst,
  feature_map_writer_if.slave bus
);

  localparam int OUT_W = out_dim(IMG_WIDTH);
  localparam int OUT_H = out_dim(IMG_HEIGHT);
  localparam int CW    = cnt_w(OUT_W);
  localparam int RW    = cnt_w(OUT_H);

  fmw_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDHT-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic                  arm, accept, rc_last;
  logic [CW-1:0]         rc_col;
  logic [RW-1:0]         rc_row;
  logic                  unused_rc;

  assign arm    = (state_q == FMW_IDLE) && bus.Start;
  assign accept = (state_q == FMW_RUN)  && bus.Valid_In;

  raster_counter #(
    .W  (OUT_W),
    .H  (OUT_H),
    .CW (CW),
    .RW (RW)
  ) u_raster (
    .clk   (clk),
    .rst_n (rst),
    .clr   (arm),
    .en    (accept),
    .col   (rc_col),
    .row   (rc_row),
    .last  (rc_last)
  );

  // Address comes from the linear index counter; row/col are only needed for the end test.
  assign unused_rc = ^{rc_col, rc_row};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FMW_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FMW_IDLE: if (bus.Start)              state_d = FMW_RUN;
      FMW_RUN:  if (bus.Valid_In && rc_last) state_d = FMW_IDLE;
      default:                               state_d = FMW_IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    if (arm) begin
      idx_d = '0;
      ovf_d = 1'b0;
    end
    // A word arriving outside RUN is lost; the drop wins over the arm-time clear.
    if ((state_q == FMW_IDLE) && bus.Valid_In) ovf_d = 1'b1;
    if (accept) begin
      we_d   = 1'b1;
      addr_d = ADDR_WIDTH'(BASE_ADDR) + idx_q;
      data_d = ((RELU_EN != 0) && bus.Data_In[SIGN_BIT]) ? '0 : bus.Data_In;
      idx_d  = idx_q + ADDR_WIDTH'(1);
      done_d = rc_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.Mem_We   = we_q;
  assign bus.Mem_Addr = addr_q;
  assign bus.Mem_Data = data_q;
  assign bus.Busy     = (state_q == FMW_RUN);
  assign bus.Done     = done_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_feature_map_writer.sv
// Scoreboard bench: DUT a (5x5 image, base 100) for raster/overflow/reset, DUT b for ReLU.
module tb_feature_map_writer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_a   = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  feature_map_writer_if #(.DATA_WIDHT(32), .ADDR_WIDTH(16)) a_if ();
  feature_map_writer_if #(.DATA_WIDHT(32), .ADDR_WIDTH(16)) b_if ();

  feature_map_writer #(
    .DATA_WIDHT(32), .IMG_WIDTH(5), .IMG_HEIGHT(5),
    .ADDR_WIDTH(16), .BASE_ADDR(100), .RELU_EN(0)
  ) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));

  feature_map_writer #(
    .DATA_WIDHT(32), .IMG_WIDTH(5), .IMG_HEIGHT(5),
    .ADDR_WIDTH(16), .BASE_ADDR(0), .RELU_EN(1)
  ) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic s, input logic v, input logic [31:0] d);
    @(posedge clk); #1;
    a_if.Start = s; a_if.Valid_In = v; a_if.Data_In = d;
  endtask

  task automatic drive_b(input logic s, input logic v, input logic [31:0] d);
    @(posedge clk); #1;
    b_if.Start = s; b_if.Valid_In = v; b_if.Data_In = d;
  endtask

  // One 3x3 output frame on DUT a; start_after >= 0 pulses Start after that word index.
  task automatic frame_a(input int gap, input int start_after, input logic [31:0] dbase);
    for (int k = 0; k < 9; k++) begin
      qa.push_back(exp_t'{addr: 16'(100 + k), data: dbase + 32'(k + 1), done: (k == 8)});
      drive_a(1'b0, 1'b1, dbase + 32'(k + 1));
      for (int g = 0; g < gap; g++) drive_a(1'b0, 1'b0, '0);
      if (k == start_after) drive_a(1'b1, 1'b0, '0);
    end
    drive_a(1'b0, 1'b0, '0);
  endtask

  task automatic settle_a(input string tag);
    repeat (3) drive_a(1'b0, 1'b0, '0);
    @(negedge clk);
    chk(tag, 64'(qa.size()), 64'd0);
  endtask

  task automatic start_a();
    drive_a(1'b1, 1'b0, '0);
    drive_a(1'b0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (a_if.Mem_We) begin
        if (qa.size() == 0) chk("a_unexpected_we", 64'(a_if.Mem_We), 64'd0);
        else begin
          ea = qa.pop_front();
          chk("a_addr", 64'(a_if.Mem_Addr), 64'(ea.addr));
          chk("a_data", 64'(a_if.Mem_Data), 64'(ea.data));
          chk("a_done", 64'(a_if.Done), 64'(ea.done));
          chk("a_busy", 64'(a_if.Busy), 64'(!ea.done));
        end
      end else if (a_if.Done) chk("a_stray_done", 64'(a_if.Done), 64'd0);
      if (a_if.Done) done_a++;
      if (b_if.Mem_We) begin
        if (qb.size() == 0) chk("b_unexpected_we", 64'(b_if.Mem_We), 64'd0);
        else begin
          eb = qb.pop_front();
          chk("b_addr", 64'(b_if.Mem_Addr), 64'(eb.addr));
          chk("b_data", 64'(b_if.Mem_Data), 64'(eb.data));
        end
      end
    end
  end

  initial begin
    a_if.Start = 0; a_if.Valid_In = 0; a_if.Data_In = '0;
    b_if.Start = 0; b_if.Valid_In = 0; b_if.Data_In = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we",   64'(a_if.Mem_We),   64'd0);
    chk("rst_busy", 64'(a_if.Busy),     64'd0);
    chk("rst_done", 64'(a_if.Done),     64'd0);
    chk("rst_ovf",  64'(a_if.Overflow), 64'd0);
    chk("rst_addr", 64'(a_if.Mem_Addr), 64'd0);
    chk("rst_data", 64'(a_if.Mem_Data), 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // consecutive frame
    start_a();
    @(negedge clk);
    chk("busy_after_start", 64'(a_if.Busy), 64'd1);
    frame_a(0, -1, 32'h0);
    settle_a("q_empty_consec");

    // gapped frame: 1 on, 2 off
    start_a();
    frame_a(2, -1, 32'h0);
    settle_a("q_empty_gapped");

    // overflow: word before Start, then a 10th word after Done
    drive_a(1'b0, 1'b1, 32'h55);
    drive_a(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("ovf_pre_start", 64'(a_if.Overflow), 64'd1);
    start_a();
    @(negedge clk);
    chk("ovf_cleared", 64'(a_if.Overflow), 64'd0);
    frame_a(0, -1, 32'h20);
    drive_a(1'b0, 1'b1, 32'h99);
    drive_a(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("ovf_after_done", 64'(a_if.Overflow), 64'd1);
    settle_a("q_empty_ovf");
    start_a();
    @(negedge clk);
    chk("ovf_cleared_again", 64'(a_if.Overflow), 64'd0);

    // reset after 4 words of a frame
    for (int k = 0; k < 4; k++) begin
      qa.push_back(exp_t'{addr: 16'(100 + k), data: 32'h70 + 32'(k), done: 1'b0});
      drive_a(1'b0, 1'b1, 32'h70 + 32'(k));
    end
    repeat (2) drive_a(1'b0, 1'b0, '0);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(a_if.Busy),     64'd0);
    chk("midrst_addr", 64'(a_if.Mem_Addr), 64'd0);
    chk("midrst_data", 64'(a_if.Mem_Data), 64'd0);
    chk("midrst_q",    64'(qa.size()),     64'd0);
    @(posedge clk); #1 rst = 1'b1;
    start_a();
    frame_a(0, -1, 32'h30);
    settle_a("q_empty_after_rst");

    // Start during RUN after word 5 is ignored
    start_a();
    frame_a(0, 4, 32'h40);
    settle_a("q_empty_restart");
    chk("done_count", 64'(done_a), 64'd5);

    // ReLU on DUT b
    drive_b(1'b1, 1'b0, '0);
    drive_b(1'b0, 1'b0, '0);
    qb.push_back(exp_t'{addr: 16'd0, data: 32'h0000_0000, done: 1'b0});
    drive_b(1'b0, 1'b1, 32'hBF80_0000);
    qb.push_back(exp_t'{addr: 16'd1, data: 32'h3F80_0000, done: 1'b0});
    drive_b(1'b0, 1'b1, 32'h3F80_0000);
    qb.push_back(exp_t'{addr: 16'd2, data: 32'h0000_0000, done: 1'b0});
    drive_b(1'b0, 1'b1, 32'h8000_0001);
    repeat (3) drive_b(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("b_q_empty", 64'(qb.size()), 64'd0);
    chk("b_busy",    64'(b_if.Busy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
